msrv32_pc_pipe_reg: RTL and testbench

//  Parametrised program-counter register for the msrv32 core, with boot sequencing,

---
 rtl/msrv32_pkg.sv | 17 +
 rtl/msrv32_pc_pipe_reg_if.sv | 27 ++
 rtl/msrv32_pc_stage.sv | 38 +++
 rtl/msrv32_pc_pipe_reg.sv | 136 +++++++++++++
 tb/tb_msrv32_pc_pipe_reg.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared types and constants for the msrv32 PC pipeline register
package msrv32_pkg;

   typedef enum logic [1:0] {
      PC_RESET = 2'd0,
      PC_BOOT  = 2'd1,
      PC_RUN   = 2'd2
   } pc_state_t;

   localparam logic [31:0] MSRV32_BOOT_ADDR = 32'h0000_0000;

   // Word alignment test on the two low bits of a fetch target
   function automatic logic is_aligned(input logic [1:0] i_lsb);
      return (i_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/msrv32_pc_pipe_reg_if.sv
// rtl/msrv32_pc_pipe_reg_if.sv - control and PC bus between the PC mux, the PC register and the pipeline
interface msrv32_pc_pipe_reg_if #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
);

   logic [WIDTH-1:0]        pc_mux_in;
   logic                    pc_load_in;
   logic                    stall_in;
   logic                    flush_in;
   logic [WIDTH-1:0]        pc_out;
   logic                    pc_valid_out;
   logic [STAGES*WIDTH-1:0] stage_pc_out;
   logic [STAGES-1:0]       stage_valid_out;
   logic                    misalign_out;

   modport master (
      output pc_mux_in, pc_load_in, stall_in, flush_in,
      input  pc_out, pc_valid_out, stage_pc_out, stage_valid_out, misalign_out
   );

   modport slave (
      input  pc_mux_in, pc_load_in, stall_in, flush_in,
      output pc_out, pc_valid_out, stage_pc_out, stage_valid_out, misalign_out
   );

endinterface

// File: rtl/msrv32_pc_stage.sv
// rtl/msrv32_pc_stage.sv - one {pc,valid} stage of the downstream PC shift chain
module msrv32_pc_stage #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_hold,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_pc,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_pc,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_pc;
   logic             r_valid;

   // Clear kills the entry but keeps its PC; hold freezes; load captures the upstream entry
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_hold) begin
         r_pc    <= r_pc;
         r_valid <= r_valid;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_valid <= i_valid;
      end
   end

   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/msrv32_pc_pipe_reg.sv
// rtl/msrv32_pc_pipe_reg.sv - program counter register with boot sequencing and PC/valid shift chain
module msrv32_pc_pipe_reg
   import msrv32_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] BOOT_ADDR = WIDTH'(MSRV32_BOOT_ADDR)
) (
   input logic                    msrv32_mp_clk_in,
   input logic                    msrv32_mp_rst_n_in,
   msrv32_pc_pipe_reg_if.slave    bus
);

   pc_state_t r_state;
   pc_state_t w_state_nxt;

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic             r_misalign;
   logic             w_misalign_nxt;

   logic             w_stg_hold;
   logic             w_stg_clear;
   logic             w_stg_load;
   logic             w_s0_valid;
   logic             w_aligned;

   logic [WIDTH-1:0] w_in_pc    [STAGES];
   logic             w_in_valid [STAGES];
   logic [WIDTH-1:0] w_stg_pc   [STAGES];
   logic             w_stg_valid[STAGES];

   logic [STAGES*WIDTH-1:0] w_stage_pc_flat;
   logic [STAGES-1:0]       w_stage_valid_flat;

   assign w_aligned = is_aligned(bus.pc_mux_in[1:0]);

   // State register; reset drops straight back to RESET from anywhere
   always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
      if (!msrv32_mp_rst_n_in) begin
         r_state <= PC_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, next PC and chain controls; flush beats stall beats load/idle
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_misalign_nxt = 1'b0;
      w_stg_hold     = 1'b1;
      w_stg_clear    = 1'b0;
      w_stg_load     = 1'b0;
      w_s0_valid     = 1'b0;
      case (r_state)
         PC_RESET: w_state_nxt = PC_BOOT;
         PC_BOOT:  w_state_nxt = PC_RUN;
         PC_RUN: begin
            w_stg_hold = 1'b0;
            if (bus.flush_in) begin
               w_stg_clear = 1'b1;
               if (w_aligned) begin
                  w_pc_nxt = bus.pc_mux_in;
               end else begin
                  w_misalign_nxt = 1'b1;
               end
            end else if (bus.stall_in) begin
               w_stg_hold = 1'b1;
            end else begin
               // Chain shifts on every non-stalled cycle; only an accepted load feeds a valid entry
               w_stg_load = 1'b1;
               if (bus.pc_load_in) begin
                  if (w_aligned) begin
                     w_pc_nxt   = bus.pc_mux_in;
                     w_s0_valid = 1'b1;
                  end else begin
                     w_misalign_nxt = 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = PC_RESET;
      endcase
   end

   // PC register and registered misalignment pulse
   always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
      if (!msrv32_mp_rst_n_in) begin
         r_pc       <= BOOT_ADDR;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_misalign <= w_misalign_nxt;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_in_pc[k]    = r_pc;
         assign w_in_valid[k] = w_s0_valid;
      end else begin : g_tail
         assign w_in_pc[k]    = w_stg_pc[k-1];
         assign w_in_valid[k] = w_stg_valid[k-1];
      end

      msrv32_pc_stage #(.WIDTH(WIDTH)) u_stage (
         .i_clk   (msrv32_mp_clk_in),
         .i_rst_n (msrv32_mp_rst_n_in),
         .i_hold  (w_stg_hold),
         .i_clear (w_stg_clear),
         .i_load  (w_stg_load),
         .i_pc    (w_in_pc[k]),
         .i_valid (w_in_valid[k]),
         .o_pc    (w_stg_pc[k]),
         .o_valid (w_stg_valid[k])
      );
   end

   // Pack stage entries onto the flat output buses
   always_comb begin
      w_stage_pc_flat    = '0;
      w_stage_valid_flat = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_stage_pc_flat[k*WIDTH +: WIDTH] = w_stg_pc[k];
         w_stage_valid_flat[k]             = w_stg_valid[k];
      end
   end

   assign bus.pc_out          = r_pc;
   assign bus.pc_valid_out    = (r_state == PC_RUN);
   assign bus.stage_pc_out    = w_stage_pc_flat;
   assign bus.stage_valid_out = w_stage_valid_flat;
   assign bus.misalign_out    = r_misalign;

endmodule

// File: tb/tb_msrv32_pc_pipe_reg.sv
// tb/tb_msrv32_pc_pipe_reg.sv - self-checking bench for msrv32_pc_pipe_reg (32b/2 stages and 64b/1 stage)
module tb_msrv32_pc_pipe_reg;

   logic clk;
   logic rst_n;

   msrv32_pc_pipe_reg_if #(.WIDTH(32), .STAGES(2)) bus_a ();
   msrv32_pc_pipe_reg_if #(.WIDTH(64), .STAGES(1)) bus_b ();

   msrv32_pc_pipe_reg #(.WIDTH(32), .STAGES(2)) dut_a (
      .msrv32_mp_clk_in   (clk),
      .msrv32_mp_rst_n_in (rst_n),
      .bus                (bus_a)
   );

   msrv32_pc_pipe_reg #(.WIDTH(64), .STAGES(1)) dut_b (
      .msrv32_mp_clk_in   (clk),
      .msrv32_mp_rst_n_in (rst_n),
      .bus                (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        load;
      logic        stall;
      logic        flush;
      logic [63:0] mux;
      logic [63:0] pc;
      logic        pcv;
      logic        mis;
      logic [63:0] s0pc;
      logic        s0v;
      logic        c0;
      logic [63:0] s1pc;
      logic        s1v;
      logic        c1;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic vec_t mk(input logic ld, input logic st, input logic fl, input logic [63:0] mx,
                               input logic [63:0] pc, input logic pcv, input logic mis,
                               input logic [63:0] s0pc, input logic s0v, input logic c0,
                               input logic [63:0] s1pc, input logic s1v, input logic c1);
      vec_t v;
      v.load = ld; v.stall = st; v.flush = fl; v.mux = mx;
      v.pc = pc; v.pcv = pcv; v.mis = mis;
      v.s0pc = s0pc; v.s0v = s0v; v.c0 = c0;
      v.s1pc = s1pc; v.s1v = s1v; v.c1 = c1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic st, input logic fl, input logic [63:0] mx);
      bus_a.pc_load_in = ld;
      bus_a.stall_in   = st;
      bus_a.flush_in   = fl;
      bus_a.pc_mux_in  = mx[31:0];
      bus_b.pc_load_in = ld;
      bus_b.stall_in   = st;
      bus_b.flush_in   = fl;
      bus_b.pc_mux_in  = mx;
   endtask

   task automatic check_vec(input vec_t e, input string tag);
      check({tag, " pc_a"},   {32'h0, bus_a.pc_out},           e.pc);
      check({tag, " pcv_a"},  64'(bus_a.pc_valid_out),         64'(e.pcv));
      check({tag, " mis_a"},  64'(bus_a.misalign_out),         64'(e.mis));
      check({tag, " s0v_a"},  64'(bus_a.stage_valid_out[0]),   64'(e.s0v));
      check({tag, " s1v_a"},  64'(bus_a.stage_valid_out[1]),   64'(e.s1v));
      if (e.c0) check({tag, " s0pc_a"}, {32'h0, bus_a.stage_pc_out[31:0]},  e.s0pc);
      if (e.c1) check({tag, " s1pc_a"}, {32'h0, bus_a.stage_pc_out[63:32]}, e.s1pc);
      check({tag, " pc_b"},   bus_b.pc_out,                    e.pc);
      check({tag, " pcv_b"},  64'(bus_b.pc_valid_out),         64'(e.pcv));
      check({tag, " mis_b"},  64'(bus_b.misalign_out),         64'(e.mis));
      check({tag, " s0v_b"},  64'(bus_b.stage_valid_out[0]),   64'(e.s0v));
      if (e.c0) check({tag, " s0pc_b"}, bus_b.stage_pc_out[63:0], e.s0pc);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " pc_a"},    {32'h0, bus_a.pc_out},             64'h0);
      check({tag, " pcv_a"},   64'(bus_a.pc_valid_out),           64'h0);
      check({tag, " mis_a"},   64'(bus_a.misalign_out),           64'h0);
      check({tag, " spc_a"},   bus_a.stage_pc_out,                64'h0);
      check({tag, " sv_a"},    64'(bus_a.stage_valid_out),        64'h0);
      check({tag, " pc_b"},    bus_b.pc_out,                      64'h0);
      check({tag, " pcv_b"},   64'(bus_b.pc_valid_out),           64'h0);
      check({tag, " mis_b"},   64'(bus_b.misalign_out),           64'h0);
      check({tag, " spc_b"},   bus_b.stage_pc_out,                64'h0);
      check({tag, " sv_b"},    64'(bus_b.stage_valid_out),        64'h0);
   endtask

   initial begin
      vec_t e;

      //          ld st fl mux        pc       pcv mis s0pc     s0v c0  s1pc     s1v c1
      vecs.push_back(mk(1, 0, 0, 64'h040, 64'h000, 0, 0, 64'h000, 0, 1, 64'h000, 0, 1)); // RESET->BOOT, load ignored
      vecs.push_back(mk(1, 0, 0, 64'h044, 64'h000, 1, 0, 64'h000, 0, 1, 64'h000, 0, 1)); // BOOT->RUN, load ignored
      vecs.push_back(mk(1, 0, 0, 64'h004, 64'h004, 1, 0, 64'h000, 1, 1, 64'h000, 0, 1));
      vecs.push_back(mk(1, 0, 0, 64'h008, 64'h008, 1, 0, 64'h004, 1, 1, 64'h000, 1, 1));
      vecs.push_back(mk(1, 0, 0, 64'h00C, 64'h00C, 1, 0, 64'h008, 1, 1, 64'h004, 1, 1));
      vecs.push_back(mk(0, 0, 0, 64'h0F0, 64'h00C, 1, 0, 64'h000, 0, 0, 64'h008, 1, 1)); // idle bubble
      vecs.push_back(mk(1, 0, 0, 64'h010, 64'h010, 1, 0, 64'h00C, 1, 1, 64'h000, 0, 0));
      vecs.push_back(mk(1, 1, 0, 64'h040, 64'h010, 1, 0, 64'h00C, 1, 1, 64'h000, 0, 0)); // stall beats load
      vecs.push_back(mk(0, 1, 0, 64'h000, 64'h010, 1, 0, 64'h00C, 1, 1, 64'h000, 0, 0));
      vecs.push_back(mk(1, 0, 0, 64'h014, 64'h014, 1, 0, 64'h010, 1, 1, 64'h00C, 1, 1));
      vecs.push_back(mk(0, 1, 1, 64'h100, 64'h100, 1, 0, 64'h010, 0, 1, 64'h00C, 0, 1)); // flush beats stall
      vecs.push_back(mk(1, 0, 0, 64'h104, 64'h104, 1, 0, 64'h100, 1, 1, 64'h010, 0, 1));
      vecs.push_back(mk(1, 0, 0, 64'h102, 64'h104, 1, 1, 64'h000, 0, 0, 64'h100, 1, 1)); // misaligned load
      vecs.push_back(mk(0, 0, 0, 64'h000, 64'h104, 1, 0, 64'h000, 0, 0, 64'h000, 0, 0));
      vecs.push_back(mk(0, 0, 1, 64'h201, 64'h104, 1, 1, 64'h000, 0, 0, 64'h000, 0, 0)); // misaligned flush
      vecs.push_back(mk(0, 1, 0, 64'h000, 64'h104, 1, 0, 64'h000, 0, 0, 64'h000, 0, 0));
      vecs.push_back(mk(1, 0, 0, 64'h108, 64'h108, 1, 0, 64'h104, 1, 1, 64'h000, 0, 0));
      vecs.push_back(mk(1, 0, 0, 64'h080, 64'h080, 1, 0, 64'h108, 1, 1, 64'h104, 1, 1));
      vecs.push_back(mk(1, 0, 0, 64'h084, 64'h084, 1, 0, 64'h080, 1, 1, 64'h108, 1, 1));
      vecs.push_back(mk(1, 0, 0, 64'h1003, 64'h084, 1, 1, 64'h000, 0, 0, 64'h080, 1, 1)); // back-to-back rejects
      vecs.push_back(mk(1, 0, 0, 64'h1001, 64'h084, 1, 1, 64'h000, 0, 0, 64'h000, 0, 0));
      vecs.push_back(mk(1, 0, 0, 64'h088, 64'h088, 1, 0, 64'h084, 1, 1, 64'h000, 0, 0));
      vecs.push_back(mk(1, 0, 0, 64'h08C, 64'h08C, 1, 0, 64'h088, 1, 1, 64'h084, 1, 1));

      drive(0, 0, 0, 64'h0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_reset("por");
      repeat (2) @(negedge clk);
      check_reset("por_hold");

      rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].load, vecs[i].stall, vecs[i].flush, vecs[i].mux);
         sb_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            check($sformatf("v%0d sb_empty", i), 64'h1, 64'h0);
         end else begin
            e = sb_q.pop_front();
            check_vec(e, $sformatf("v%0d", i));
         end
         @(negedge clk);
      end

      // Mid-run asynchronous reset: outputs must drop before the next edge
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset("async_rst");
      repeat (2) @(negedge clk);
      check_reset("async_rst_hold");

      // Second boot: one BOOT cycle with load ignored, then RUN accepts loads
      drive(1, 0, 0, 64'h040);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("boot2 pc_a",  {32'h0, bus_a.pc_out},   64'h0);
      check("boot2 pcv_a", 64'(bus_a.pc_valid_out), 64'h0);
      check("boot2 pc_b",  bus_b.pc_out,            64'h0);
      check("boot2 pcv_b", 64'(bus_b.pc_valid_out), 64'h0);
      @(negedge clk);
      @(posedge clk); #1;
      check("run2 pc_a",  {32'h0, bus_a.pc_out},   64'h0);
      check("run2 pcv_a", 64'(bus_a.pc_valid_out), 64'h1);
      check("run2 pcv_b", 64'(bus_b.pc_valid_out), 64'h1);
      @(negedge clk);
      drive(1, 0, 0, 64'h020);
      @(posedge clk); #1;
      check("run2 load pc_a",  {32'h0, bus_a.pc_out},          64'h20);
      check("run2 load pc_b",  bus_b.pc_out,                   64'h20);
      check("run2 load s0v_b", 64'(bus_b.stage_valid_out[0]),  64'h1);
      check("run2 load s0pc_b", bus_b.stage_pc_out,            64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
